mem_port_arbiter: RTL and testbench

- Shares one downstream memory port between the pipeline's two requesters: port A (instruction fetch, read-only) and port B (data load/store).
- Sits between the CPU datapath ports and the unified cache/physical memory.
- Serves one transaction at a time. Port B wins ties by default; a starvation counter forces a grant to A after repeated lost ties.
- Requests are captured at grant, and the downstream port is driven from those registered copies.

---
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (A) and load/store (B), one transaction at a time
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MASK_W   = 2,
    parameter int MAX_SKIP = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              read_a,
    input  logic [ADDR_W-1:0] address_a,
    output logic              resp_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              read_b,
    input  logic              write_b,
    input  logic [MASK_W-1:0] wmask_b,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              resp_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B, RECOVER} state_t;
    localparam int SKIP_W = $clog2(MAX_SKIP + 1);

    state_t              state, state_nx;
    logic [SKIP_W-1:0]   skip_cnt, skip_nx;
    logic [ADDR_W-1:0]   lat_address;
    logic [DATA_W-1:0]   lat_wdata;
    logic [MASK_W-1:0]   lat_wmask;
    logic                lat_write;
    logic                req_a, req_b, grant_a, grant_b, busy_a, busy_b, busy;

    assign req_a   = read_a;
    assign req_b   = read_b | write_b;
    assign grant_a = (state == IDLE) && req_a && (!req_b || skip_cnt == SKIP_W'(MAX_SKIP));
    assign grant_b = (state == IDLE) && req_b && !grant_a;
    assign busy_a  = (state == BUSY_A);
    assign busy_b  = (state == BUSY_B);
    assign busy    = busy_a | busy_b;

    // next state and starvation count; the count only moves on a grant
    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        case (state)
            IDLE: begin
                if (grant_a) begin
                    state_nx = BUSY_A;
                    skip_nx  = '0;
                end else if (grant_b) begin
                    state_nx = BUSY_B;
                    skip_nx  = req_a ? skip_cnt + SKIP_W'(1) : skip_cnt;
                end
            end
            BUSY_A, BUSY_B: state_nx = mem_resp ? RECOVER : state;
            default:        state_nx = IDLE;
        endcase
    end

    // state register plus the winner's request captured on the granting edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            skip_cnt    <= '0;
            lat_address <= '0;
            lat_wdata   <= '0;
            lat_wmask   <= '0;
            lat_write   <= 1'b0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_nx;
            if (grant_a) begin
                lat_address <= address_a;
                lat_wdata   <= '0;
                lat_wmask   <= '0;
                lat_write   <= 1'b0;
            end else if (grant_b) begin
                lat_address <= address_b;
                lat_wdata   <= wdata_b;
                lat_wmask   <= wmask_b;
                lat_write   <= write_b;
            end
        end
    end

    assign mem_read    = busy & ~lat_write;
    assign mem_write   = busy & lat_write;
    assign mem_address = busy ? lat_address : '0;
    assign mem_wdata   = busy ? lat_wdata : '0;
    assign mem_wmask   = busy ? lat_wmask : '0;
    assign resp_a      = busy_a & mem_resp;
    assign resp_b      = busy_b & mem_resp;
    assign rdata_a     = (busy_a && !lat_write) ? mem_rdata : '0;
    assign rdata_b     = (busy_b && !lat_write) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter against a transaction-level arbitration model
module tb_mem_port_arbiter;
    localparam int MS = 3;

    typedef struct {bit v; bit wr; bit rd; logic [15:0] addr; logic [15:0] wdata; logic [1:0] mask;} req_t;
    typedef struct {logic wr; logic [15:0] addr; logic [15:0] wdata; logic [1:0] mask;} mem_t;
    typedef struct {logic b; logic [15:0] rdata;} rsp_t;

    logic clk = 1'b0, reset_n = 1'b0;
    logic read_a = 1'b0, read_b = 1'b0, write_b = 1'b0, mem_resp = 1'b0;
    logic [15:0] address_a = '0, address_b = '0, wdata_b = '0, mem_rdata = '0;
    logic [1:0] wmask_b = '0;
    logic resp_a, resp_b, mem_read, mem_write;
    logic [15:0] rdata_a, rdata_b, mem_address, mem_wdata;
    logic [1:0] mem_wmask;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MASK_W(2), .MAX_SKIP(MS)) dut (
        .clk(clk), .reset_n(reset_n),
        .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    int errs = 0, checks = 0;
    mem_t mem_q[$];
    rsp_t rsp_q[$];
    req_t pend_a, pend_b;
    int skip = 0;
    bit scramble = 1'b0, stray_en = 1'b0, force_resp = 1'b0;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5AC3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // memory responder: answers a strobe after a random latency; read data is a fixed function of the address
    int lat = 0;
    always @(posedge clk) begin
        #2;
        if (mem_read | mem_write) begin
            if (lat == 0) begin
                mem_resp  = 1'b1;
                mem_rdata = mem_model(mem_address);
                lat       = $urandom_range(0, 3);
            end else begin
                mem_resp = 1'b0;
                lat--;
            end
        end else begin
            mem_resp  = force_resp | (stray_en && ($urandom % 4 == 0));
            mem_rdata = 16'($urandom);
        end
    end

    // monitor: pops expected commands at each new strobe and expected completions at each resp
    mem_t cur;
    rsp_t r;
    logic prev_s = 1'b0, s;
    int gap = 100;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_s = 1'b0;
            gap    = 100;
        end else begin
            s = mem_read | mem_write;
            if (s && !prev_s) begin
                chk("grant_spacing", 64'(gap >= 2), 64'd1);
                chk("grant_expected", 64'(mem_q.size() != 0), 64'd1);
                if (mem_q.size() != 0) cur = mem_q.pop_front();
            end
            if (s) begin
                chk("mem_cmd", 64'({mem_read, mem_write, mem_address, mem_wdata, mem_wmask}),
                    64'({~cur.wr, cur.wr, cur.addr, cur.wdata, cur.mask}));
                gap = 0;
            end else begin
                chk("idle_zero", 64'({mem_address, mem_wdata, mem_wmask}), 64'd0);
                gap++;
            end
            if (resp_a | resp_b) begin
                chk("resp_expected", 64'(rsp_q.size() != 0), 64'd1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    chk("resp_port", 64'({resp_a, resp_b}), r.b ? 64'd1 : 64'd2);
                    chk("rdata_winner", 64'(r.b ? rdata_b : rdata_a), 64'(r.rdata));
                    chk("rdata_other", 64'(r.b ? rdata_a : rdata_b), 64'd0);
                end
            end
            prev_s = s;
        end
    end

    task automatic new_a();
        pend_a = '{1'b1, 1'b0, 1'b1, {1'b0, 15'($urandom)}, 16'h0, 2'b00};
    endtask

    task automatic new_b();
        bit wr;
        wr = 1'($urandom);
        pend_b = '{1'b1, wr, wr ? 1'($urandom) : 1'b1, {1'b1, 15'($urandom)}, 16'($urandom), 2'($urandom)};
    endtask

    task automatic drive_inputs();
        read_a    = pend_a.v;
        address_a = pend_a.addr;
        read_b    = pend_b.v & pend_b.rd;
        write_b   = pend_b.v & pend_b.wr;
        address_b = pend_b.addr;
        wdata_b   = pend_b.wdata;
        wmask_b   = pend_b.mask;
    endtask

    // one transaction: present pending requests, predict the winner, wait for its completion, land in RECOVER
    task automatic round();
        bit win_b, got;
        req_t w;
        int n;
        drive_inputs();
        if (pend_a.v && pend_b.v) begin
            win_b = skip < MS;
            skip  = win_b ? skip + 1 : 0;
        end else if (pend_a.v) begin
            win_b = 1'b0;
            skip  = 0;
        end else begin
            win_b = 1'b1;
        end
        w = win_b ? pend_b : pend_a;
        mem_q.push_back('{w.wr, w.addr, w.wdata, w.mask});
        rsp_q.push_back('{win_b, w.wr ? 16'h0 : mem_model(w.addr)});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            got = win_b ? resp_b : resp_a;
            if (!got && scramble && (mem_read | mem_write)) begin
                if (win_b) begin
                    address_b = 16'($urandom);
                    wdata_b   = 16'($urandom);
                    wmask_b   = 2'($urandom);
                end else begin
                    address_a = 16'($urandom);
                end
            end
        end while (!got && n < 60);
        chk("resp_timeout", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        if (win_b) pend_b.v = 1'b0;
        else pend_a.v = 1'b0;
        drive_inputs();
    endtask

    initial begin
        int n;
        pend_a = '{1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b0};
        pend_b = pend_a;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({resp_a, resp_b, rdata_a, rdata_b, mem_read, mem_write, mem_address, mem_wdata, mem_wmask}), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        scramble = 1'b1;
        pend_b = '{1'b1, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 2'b01};
        round();
        pend_a = '{1'b1, 1'b0, 1'b1, 16'h0040, 16'h0, 2'b00};
        round();
        scramble = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!pend_a.v) new_a();
            if (!pend_b.v) new_b();
            round();
        end
        stray_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            scramble = 1'($urandom);
            if (!pend_a.v && ($urandom % 2 == 0)) new_a();
            if (!pend_b.v && ($urandom % 2 == 0)) new_b();
            if (!pend_a.v && !pend_b.v) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                continue;
            end
            round();
        end
        stray_en = 1'b0;
        while (pend_a.v || pend_b.v) round();
        new_b();
        drive_inputs();
        mem_q.push_back('{pend_b.wr, pend_b.addr, pend_b.wdata, pend_b.mask});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_read | mem_write) && n < 20);
        chk("busy_before_reset", 64'(mem_read | mem_write), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({resp_a, resp_b, rdata_a, rdata_b, mem_read, mem_write, mem_address, mem_wdata, mem_wmask}), 64'd0);
        pend_a.v = 1'b0;
        pend_b.v = 1'b0;
        drive_inputs();
        rsp_q.delete();
        mem_q.delete();
        skip = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n    = 1'b1;
        force_resp = 1'b1;
        @(negedge clk);
        chk("late_resp_ignored", 64'({mem_resp, resp_a, resp_b, mem_read, mem_write}), 64'h10);
        @(posedge clk);
        #1;
        force_resp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!pend_a.v) new_a();
            if (!pend_b.v) new_b();
            round();
        end
        while (pend_a.v || pend_b.v) round();
        repeat (4) @(negedge clk);
        chk("queues_drained", 64'(mem_q.size() + rsp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
